// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle control FSM: opcodes, states, ALU ops and
// the instruction classes produced by the decoder.
package control_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH0 = 3'd0,
    S_FETCH1 = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_BAD
  } cls_t;

endpackage

// File: rtl/control_decode.sv
// Combinational classification of a latched opcode/funct3 into an instruction
// class, plus whether a branch funct3 is one the datapath supports.
module control_decode
  import control_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output cls_t       cls,
  output logic       br_ok
);

  always_comb begin
    cls = CLS_BAD;
    case (opcode)
      OP_R:      cls = CLS_R;
      OP_I:      cls = CLS_I;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_BRANCH: cls = CLS_BRANCH;
      default:   cls = CLS_BAD;
    endcase
  end

  // Only beq (000) and bne (001) are implemented.
  assign br_ok = (funct3 == 3'b000) || (funct3 == 3'b001);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the RV64 subset datapath: sequences fetch, decode,
// execute, memory and writeback, counts cycles/retirements, halts on faults.
module multicycle_control
  import control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             alu_zero,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ir_write,
  output logic             reg_write,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic             bus_error,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            cur;
  logic [6:0]        ir_op;
  logic [2:0]        ir_f3;
  logic [WAIT_W-1:0] wait_cnt;
  logic              pc_hold;
  cls_t              cls;
  logic              br_ok;
  logic              taken;

  // The rest of the word belongs to the datapath (register and immediate fields).
  logic unused_fields;
  assign unused_fields = ^{instr[31:15], instr[11:7]};

  control_decode u_decode (
    .opcode (ir_op),
    .funct3 (ir_f3),
    .cls    (cls),
    .br_ok  (br_ok)
  );

  assign taken    = ((ir_f3 == 3'b000) && alu_zero) || ((ir_f3 == 3'b001) && !alu_zero);
  assign pc_src   = (cur == S_EXEC) && (cls == CLS_BRANCH) && taken;
  // A store retires the same cycle memory answers, so its PC load cannot wait a cycle.
  assign pc_write = pc_hold || ((cur == S_MEM) && (cls == CLS_STORE) && dmem_ready);
  assign state    = cur;

  // Outputs are loaded with the values belonging to the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur         <= S_FETCH0;
      ir_op       <= '0;
      ir_f3       <= '0;
      wait_cnt    <= '0;
      pc_hold     <= 1'b0;
      ir_write    <= 1'b0;
      reg_write   <= 1'b0;
      alu_src_b   <= 1'b0;
      alu_op      <= ALU_ADD;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_to_reg  <= 1'b0;
      illegal     <= 1'b0;
      bus_error   <= 1'b0;
      cycle_count <= '0;
      instret     <= '0;
    end else begin
      cycle_count <= cycle_count + CNT_W'(1);
      pc_hold     <= 1'b0;
      ir_write    <= 1'b0;
      reg_write   <= 1'b0;
      alu_src_b   <= 1'b0;
      alu_op      <= ALU_ADD;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_to_reg  <= 1'b0;
      case (cur)
        S_FETCH0: begin
          cur      <= S_FETCH1;
          ir_write <= 1'b1;
        end
        S_FETCH1: begin
          cur   <= S_DECODE;
          ir_op <= instr[6:0];
          ir_f3 <= instr[14:12];
        end
        S_DECODE: begin
          if (cls == CLS_BAD) begin
            cur     <= S_HALT;
            illegal <= 1'b1;
          end else begin
            cur <= S_EXEC;
            case (cls)
              CLS_R:      begin alu_src_b <= 1'b0; alu_op <= ALU_FUNCT; end
              CLS_I:      begin alu_src_b <= 1'b1; alu_op <= ALU_FUNCT; end
              CLS_BRANCH: begin alu_src_b <= 1'b0; alu_op <= ALU_SUB; pc_hold <= br_ok; end
              default:    begin alu_src_b <= 1'b1; alu_op <= ALU_ADD; end
            endcase
          end
        end
        S_EXEC: begin
          case (cls)
            CLS_BRANCH: begin
              if (br_ok) begin
                cur     <= S_FETCH0;
                instret <= instret + CNT_W'(1);
              end else begin
                cur     <= S_HALT;
                illegal <= 1'b1;
              end
            end
            CLS_LOAD:  begin cur <= S_MEM; mem_read  <= 1'b1; wait_cnt <= '0; end
            CLS_STORE: begin cur <= S_MEM; mem_write <= 1'b1; wait_cnt <= '0; end
            default: begin
              cur       <= S_WB;
              reg_write <= 1'b1;
              pc_hold   <= 1'b1;
            end
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (cls == CLS_LOAD) begin
              cur        <= S_WB;
              reg_write  <= 1'b1;
              mem_to_reg <= 1'b1;
              pc_hold    <= 1'b1;
            end else begin
              cur     <= S_FETCH0;
              instret <= instret + CNT_W'(1);
            end
          end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
            cur       <= S_HALT;
            bus_error <= 1'b1;
          end else begin
            wait_cnt  <= wait_cnt + WAIT_W'(1);
            mem_read  <= (cls == CLS_LOAD);
            mem_write <= (cls == CLS_STORE);
          end
        end
        S_WB: begin
          cur     <= S_FETCH0;
          instret <= instret + CNT_W'(1);
        end
        S_HALT:  cur <= S_HALT;
        default: cur <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a per-instruction trace model derived from the
// instruction-class latency and output rules, compared every cycle.
module tb_multicycle_control;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_BAD = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        alu_zero = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        pc_write, pc_src, ir_write, reg_write, alu_src_b;
  logic [1:0]  alu_op;
  logic        mem_read, mem_write, mem_to_reg, illegal, bus_error;
  logic [2:0]  state;
  logic [31:0] cycle_count, instret;

  logic        w_reset = 1'b0;
  logic        w_pc_write, w_pc_src, w_ir_write, w_reg_write, w_alu_src_b;
  logic [1:0]  w_alu_op;
  logic        w_mem_read, w_mem_write, w_mem_to_reg, w_illegal, w_bus_error;
  logic [2:0]  w_state;
  logic [3:0]  w_cycle_count, w_instret;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_cyc = 0;
  logic [31:0] m_ret = 0;

  logic [14:0] exp_q[$];
  bit          rdy_q[$];
  bit          ret_q[$];

  logic [14:0] obs;
  assign obs = {state, pc_write, pc_src, ir_write, reg_write, alu_src_b, alu_op,
                mem_read, mem_write, mem_to_reg, illegal, bus_error};

  always #5 clk = ~clk;

  multicycle_control u_dut (
    .clk(clk), .reset(reset), .instr(instr), .alu_zero(alu_zero), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .reg_write(reg_write),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .bus_error(bus_error), .state(state),
    .cycle_count(cycle_count), .instret(instret)
  );

  multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(4)) u_wrap (
    .clk(clk), .reset(w_reset), .instr(32'hFFFF_FFFF), .alu_zero(1'b0), .dmem_ready(1'b0),
    .pc_write(w_pc_write), .pc_src(w_pc_src), .ir_write(w_ir_write), .reg_write(w_reg_write),
    .alu_src_b(w_alu_src_b), .alu_op(w_alu_op), .mem_read(w_mem_read), .mem_write(w_mem_write),
    .mem_to_reg(w_mem_to_reg), .illegal(w_illegal), .bus_error(w_bus_error), .state(w_state),
    .cycle_count(w_cycle_count), .instret(w_instret)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // One expected cycle: state, pc_write, pc_src, ir_write, reg_write, alu_src_b,
  // alu_op, mem_read, mem_write, mem_to_reg, illegal, bus_error.
  task automatic push(input logic [2:0] st, input logic pw, input logic ps, input logic irw,
                      input logic rw, input logic asb, input logic [1:0] aop, input logic mr,
                      input logic mw, input logic m2r, input logic ill, input logic be,
                      input bit rdy, input bit ret);
    exp_q.push_back({st, pw, ps, irw, rw, asb, aop, mr, mw, m2r, ill, be});
    rdy_q.push_back(rdy);
    ret_q.push_back(ret);
  endtask

  function automatic bit noise();
    return bit'($urandom_range(0, 1));
  endfunction

  // Expected trace of one instruction from its class, branch outcome and memory waits.
  task automatic model_instr(input int kind, input logic [2:0] f3, input bit zero, input int waits);
    bit halt_ill = 0, halt_be = 0, ld, legal, tk;
    ld = (kind == K_LD);
    push(3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, noise(), 0);
    push(3'd1, 0, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0, noise(), 0);
    push(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, noise(), 0);
    case (kind)
      K_R, K_I: begin
        push(3'd3, 0, 0, 0, 0, kind == K_I, 2'd2, 0, 0, 0, 0, 0, noise(), 0);
        push(3'd5, 1, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0, noise(), 1);
      end
      K_LD, K_ST: begin
        push(3'd3, 0, 0, 0, 0, 1, 2'd0, 0, 0, 0, 0, 0, noise(), 0);
        if (waits >= 15) begin
          for (int i = 0; i < 15; i++) push(3'd4, 0, 0, 0, 0, 0, 2'd0, ld, !ld, 0, 0, 0, 0, 0);
          halt_be = 1;
        end else begin
          for (int i = 0; i < waits; i++) push(3'd4, 0, 0, 0, 0, 0, 2'd0, ld, !ld, 0, 0, 0, 0, 0);
          if (ld) begin
            push(3'd4, 0, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0, 0, 1, 0);
            push(3'd5, 1, 0, 0, 1, 0, 2'd0, 0, 0, 1, 0, 0, noise(), 1);
          end else begin
            push(3'd4, 1, 0, 0, 0, 0, 2'd0, 0, 1, 0, 0, 0, 1, 1);
          end
        end
      end
      K_BR: begin
        legal = (f3 == 3'b000) || (f3 == 3'b001);
        tk    = ((f3 == 3'b000) && zero) || ((f3 == 3'b001) && !zero);
        push(3'd3, legal, tk, 0, 0, 0, 2'd1, 0, 0, 0, 0, 0, noise(), legal);
        halt_ill = !legal;
      end
      default: halt_ill = 1;
    endcase
    if (halt_ill || halt_be)
      repeat (3) push(3'd7, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, halt_ill, halt_be, noise(), 0);
  endtask

  task automatic run_queue(input int max_cycles);
    logic [14:0] e;
    bit r;
    int n = 0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      @(negedge clk);
      e = exp_q.pop_front();
      dmem_ready = rdy_q.pop_front();
      r = ret_q.pop_front();
      #1;
      check("trace", obs, e);
      check("cycle_count", cycle_count, m_cyc);
      check("instret", instret, m_ret);
      if (r) m_ret++;
      m_cyc++;
      n++;
    end
    exp_q.delete();
    rdy_q.delete();
    ret_q.delete();
  endtask

  task automatic do_instr(input logic [31:0] word, input int kind, input bit zero, input int waits);
    instr    = word;
    alu_zero = zero;
    model_instr(kind, word[14:12], zero, waits);
    run_queue(1000);
  endtask

  task automatic apply_reset(input bit rdy_during);
    @(negedge clk);
    dmem_ready = rdy_during;
    reset = 1'b0;
    #1;
    check("reset_outputs", obs, 15'd0);
    check("reset_cycle_count", cycle_count, 32'd0);
    check("reset_instret", instret, 32'd0);
    @(posedge clk);
    #1;
    check("reset_hold_state", state, 3'd0);
    #1;
    reset = 1'b1;
    dmem_ready = 1'b0;
    m_cyc = 0;
    m_ret = 0;
  endtask

  function automatic logic [31:0] mk_instr(input int kind, input logic [2:0] f3);
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom;
    case (kind)
      K_R:     op = 7'b0110011;
      K_I:     op = 7'b0010011;
      K_LD:    op = 7'b0000011;
      K_ST:    op = 7'b0100011;
      default: op = 7'b1100011;
    endcase
    if (kind == K_BR) return {r[31:15], f3, r[11:7], op};
    return {r[31:7], op};
  endfunction

  initial begin
    int k, w;
    bit z;
    apply_reset(1'b0);

    do_instr(32'h0050_0093, K_I, 0, 0);
    @(posedge clk);
    #1;
    check("addi_cycle_count", cycle_count, 32'd5);
    check("addi_instret", instret, 32'd1);
    do_instr(32'h0020_81B3, K_R, 0, 0);
    do_instr(32'h0080_A283, K_LD, 0, 3);
    do_instr(32'h0050_A623, K_ST, 1, 0);
    do_instr(32'h0020_8463, K_BR, 1, 0);
    do_instr(32'h0020_8463, K_BR, 0, 0);
    do_instr(32'h0020_9463, K_BR, 1, 0);
    do_instr(32'h0020_9463, K_BR, 0, 0);

    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(0, 4);
      w = $urandom_range(0, 4);
      z = bit'($urandom_range(0, 1));
      do_instr(mk_instr(k, 3'($urandom_range(0, 1))), k, z, w);
    end

    // Reset in the middle of a load wait, with ready arriving the same cycle.
    instr = 32'h0080_A283;
    model_instr(K_LD, 3'b010, 0, 20);
    run_queue(6);
    apply_reset(1'b1);

    do_instr(32'hFFFF_FFFF, K_BAD, 0, 0);
    apply_reset(1'b0);
    do_instr(32'h0000_006F, K_BAD, 0, 0);
    apply_reset(1'b0);
    do_instr(32'h0020_A463, K_BR, 1, 0);
    apply_reset(1'b0);
    do_instr(32'h0080_A283, K_LD, 0, 15);
    apply_reset(1'b0);
    do_instr(32'h0050_A623, K_ST, 0, 15);
    apply_reset(1'b0);
    do_instr(32'h0020_81B3, K_R, 0, 0);

    // Narrow-counter instance: cycle_count wraps from all-ones to zero.
    @(posedge clk);
    #2;
    w_reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("wrap_max", w_cycle_count, 4'hF);
    @(posedge clk);
    #1;
    check("wrap_zero", w_cycle_count, 4'h0);
    check("wrap_halted", {w_state, w_illegal}, {3'd7, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
